// File: rtl/fp_to_i2s_tx.sv
// fp_to_i2s_tx: float-to-PCM converter, sample FIFO and I2S transmitter.
// Each popped sample is sent in both slots, MSB first, one BCLK after LRCLK moves.
module fp_to_i2s_tx #(
    parameter int PCM_WIDTH  = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    input  logic        mute,
    input  logic        status_clr,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_strobe,
    output logic        fifo_full,
    output logic        clip,
    output logic        overflow,
    output logic        underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_WIDTH);

    localparam logic [8:0]           SH_BASE  = 9'(151 - PCM_WIDTH);
    localparam logic [PCM_WIDTH-1:0] POS_MAX  = {1'b0, {(PCM_WIDTH-1){1'b1}}};
    localparam logic [PCM_WIDTH-1:0] NEG_MAX  = {1'b1, {(PCM_WIDTH-1){1'b0}}};
    localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [DW-1:0]        DIV_TC   = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0]        BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0]        SLOT_B   = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0]        PCM_B    = BW'(PCM_WIDTH);

    logic                 s1_valid;
    logic                 s1_sign;
    logic [7:0]           s1_exp;
    logic [22:0]          s1_man;
    logic [8:0]           shamt;
    logic [23:0]          mag;
    logic [PCM_WIDTH-1:0] s2_word;
    logic                 s2_clip;

    logic [PCM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_empty;
    logic                 pop;
    logic                 wr_ok;

    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        slot_pos;
    logic                 tick;
    logic                 boundary;
    logic [PCM_WIDTH-1:0] frame_word;
    logic [PCM_WIDTH-1:0] slot_word;

    // Stage 1: split the incoming float into sign, exponent and mantissa.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                s1_sign <= sample_in[31];
                s1_exp  <= sample_in[30:23];
                s1_man  <= sample_in[22:0];
            end
        end
    end

    // Stage 2: saturating, truncating conversion to signed PCM.
    always_comb begin
        s2_word = '0;
        s2_clip = 1'b0;
        mag     = '0;
        shamt   = SH_BASE - {1'b0, s1_exp};
        if (s1_exp == 8'hFF) begin
            if (s1_man == '0) begin
                s2_word = s1_sign ? NEG_MAX : POS_MAX;
                s2_clip = 1'b1;
            end
        end else if (s1_exp >= 8'd127) begin
            if (s1_sign && s1_exp == 8'd127 && s1_man == '0) begin
                s2_word = NEG_MAX;
            end else begin
                s2_word = s1_sign ? NEG_MAX : POS_MAX;
                s2_clip = 1'b1;
            end
        end else begin
            if (shamt < 9'd24) begin
                mag = {1'b1, s1_man} >> shamt;
            end
            s2_word = s1_sign ? -mag[PCM_WIDTH-1:0] : mag[PCM_WIDTH-1:0];
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = boundary && !fifo_empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign wr_ok      = s1_valid && (!fifo_full || pop);

    // Sample storage; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= s2_word;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign tick     = (div_cnt == DIV_TC);
    assign boundary = tick && bclk && (bit_idx == BIT_LAST);

    // BCLK divider and bit index; the index moves only on BCLK falling edges.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_idx <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame register, frame pulse, clip pulse and sticky status flags.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            frame_word   <= '0;
            frame_strobe <= 1'b0;
            clip         <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= boundary;
            clip         <= s1_valid && s2_clip;
            if (boundary) begin
                frame_word <= (mute || fifo_empty) ? '0 : mem[rd_ptr];
            end
            overflow <= status_clr ? 1'b0 : (overflow || (s1_valid && !wr_ok));
            underrun <= status_clr ? 1'b0 : (underrun || (boundary && fifo_empty));
        end
    end

    assign lrclk    = (bit_idx >= SLOT_B);
    assign slot_pos = lrclk ? (bit_idx - SLOT_B) : bit_idx;

    // Serial data: word bits MSB first at slot positions 1..PCM_WIDTH, zero elsewhere.
    always_comb begin
        sdata     = 1'b0;
        slot_word = frame_word >> (PCM_B - slot_pos);
        if (slot_pos != '0 && slot_pos <= PCM_B) begin
            sdata = slot_word[0];
        end
    end

endmodule

// File: tb/tb_fp_to_i2s_tx.sv
// Directed testbench for fp_to_i2s_tx at default parameters.
module tb_fp_to_i2s_tx;

    logic        clk;
    logic        aclr;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        mute;
    logic        status_clr;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_strobe;
    logic        fifo_full;
    logic        clip;
    logic        overflow;
    logic        underrun;

    int total = 0;
    int bad   = 0;
    int cyc;

    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;
    localparam int NV = 12;
    localparam logic [31:0] VIN [NV] = '{
        32'h3F000000, 32'hBF800000, 32'h3F800000, 32'hFF800000,
        32'h7FC00000, 32'h3A800000, 32'h33000000, 32'hBA800000,
        32'h3F7FFFFF, 32'hC0000000, 32'h00000001, 32'h7F800000};
    localparam logic [23:0] VOUT [NV] = '{
        24'h400000, 24'h800000, 24'h7FFFFF, 24'h800000,
        24'h000000, 24'h002000, 24'h000000, 24'hFFE000,
        24'h7FFFFF, 24'h800000, 24'h000000, 24'h7FFFFF};
    localparam logic VCLIP [NV] = '{
        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    fp_to_i2s_tx #(
        .PCM_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .aclr(aclr), .sample_in(sample_in), .sample_valid(sample_valid),
        .mute(mute), .status_clr(status_clr), .bclk(bclk), .lrclk(lrclk),
        .sdata(sdata), .frame_strobe(frame_strobe), .fifo_full(fifo_full),
        .clip(clip), .overflow(overflow), .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge aclr) begin
        if (aclr) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Expected 64-bit frame pattern (bit j = sdata at bit index j).
    function automatic logic [63:0] exp_bits(input logic [23:0] w);
        logic [63:0] e;
        e = '0;
        for (int j = 0; j < 64; j++) begin
            int p;
            p = j % 32;
            if (p >= 1 && p <= 24) e[6'(j)] = w[5'(24 - p)];
        end
        return e;
    endfunction

    task automatic wait_strobe(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (frame_strobe) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL strobe_timeout %s: no frame_strobe within 600 cycles", tag);
        end
    endtask

    // Called on the strobe cycle; samples each bit index once, ends at b=63.
    task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
        sd = '0;
        lr = '0;
        sd[0] = sdata;
        lr[0] = lrclk;
        for (int j = 1; j < 64; j++) begin
            repeat (8) @(negedge clk);
            sd[6'(j)] = sdata;
            lr[6'(j)] = lrclk;
        end
    endtask

    task automatic send(input logic [31:0] x);
        @(negedge clk);
        sample_in    = x;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic clear_status();
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] bpat;
        logic [63:0] sd, lr;
        logic        seen;
        bit          found;
        aclr = 1'b1; sample_valid = 1'b0; mute = 1'b0; status_clr = 1'b0; sample_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bclk, lrclk, sdata, frame_strobe, fifo_full, clip, overflow, underrun} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {bclk, lrclk, sdata, frame_strobe, fifo_full, clip, overflow, underrun});
        end
        aclr = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bpat[4'(k)] = bclk;
        end
        total++;
        if (bpat !== 12'h878) begin
            bad++;
            $display("FAIL bclk_pattern: got %h want 878", bpat);
        end
        send(32'h3F000000);
        @(negedge clk);
        total++;
        if (clip !== 1'b0) begin
            bad++;
            $display("FAIL reset_clip: got %b want 0", clip);
        end
        seen  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (frame_strobe) begin
                found = 1'b1;
                break;
            end
            seen = seen | sdata;
        end
        total++;
        if (!found || cyc !== 512) begin
            bad++;
            $display("FAIL first_strobe_cycle: got %0d (found=%0b) want 512", cyc, found);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL first_frame_silent: got sdata activity %b want 0", seen);
        end
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL first_frame_underrun: got %b want 0", underrun);
        end
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_bits(24'h400000)) begin
            bad++;
            $display("FAIL first_frame_data: got %h want %h", sd, exp_bits(24'h400000));
        end
        total++;
        if (lr !== LR_EXP) begin
            bad++;
            $display("FAIL lrclk_pattern: got %h want %h", lr, LR_EXP);
        end
    endtask

    task automatic test_conversions();
        logic [63:0] sd, lr;
        for (int i = 0; i < NV; i++) begin
            wait_strobe("conv_pre");
            send(VIN[i]);
            total++;
            if (clip !== 1'b0) begin
                bad++;
                $display("FAIL conv_clip_early[%0d]: got %b want 0", i, clip);
            end
            @(negedge clk);
            total++;
            if (clip !== VCLIP[i]) begin
                bad++;
                $display("FAIL conv_clip[%0d] in=%h: got %b want %b", i, VIN[i], clip, VCLIP[i]);
            end
            wait_strobe("conv_tx");
            capture_frame(sd, lr);
            total++;
            if (sd !== exp_bits(VOUT[i])) begin
                bad++;
                $display("FAIL conv_data[%0d] in=%h: got %h want %h", i, VIN[i], sd, exp_bits(VOUT[i]));
            end
            total++;
            if (lr !== LR_EXP) begin
                bad++;
                $display("FAIL conv_lrclk[%0d]: got %h want %h", i, lr, LR_EXP);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] din [5];
        logic [23:0] ew [4];
        logic [63:0] sd, lr;
        int          s;
        din[0] = 32'h3F000000; din[1] = 32'hBF000000; din[2] = 32'h3A800000;
        din[3] = 32'hBA800000; din[4] = 32'h3E800000;
        ew[0] = 24'hC00000; ew[1] = 24'h002000; ew[2] = 24'hFFE000; ew[3] = 24'hE00000;
        wait_strobe("ovf_start");
        s = cyc;
        clear_status();
        total++;
        if ({overflow, underrun} !== 2'b00) begin
            bad++;
            $display("FAIL ovf_clear_flags: got %b want 00", {overflow, underrun});
        end
        @(negedge clk);
        sample_in    = din[0];
        sample_valid = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            sample_in = din[i];
        end
        total++;
        if (fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL full_at_three: got %b want 0", fifo_full);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        total++;
        if ({fifo_full, overflow} !== 2'b10) begin
            bad++;
            $display("FAIL full_at_four: got full,ovf=%b want 10", {fifo_full, overflow});
        end
        @(negedge clk);
        total++;
        if ({fifo_full, overflow} !== 2'b11) begin
            bad++;
            $display("FAIL fifth_dropped: got full,ovf=%b want 11", {fifo_full, overflow});
        end
        clear_status();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_status_clr: got %b want 0", overflow);
        end
        while (cyc < s + 510) @(negedge clk);
        sample_in    = 32'hBE800000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({frame_strobe, fifo_full, overflow} !== 3'b110) begin
            bad++;
            $display("FAIL pop_write_full: got strobe,full,ovf=%b want 110",
                     {frame_strobe, fifo_full, overflow});
        end
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_bits(24'h400000)) begin
            bad++;
            $display("FAIL fifo_order[0]: got %h want %h", sd, exp_bits(24'h400000));
        end
        for (int k = 0; k < 4; k++) begin
            wait_strobe("fifo_order");
            capture_frame(sd, lr);
            total++;
            if (sd !== exp_bits(ew[k])) begin
                bad++;
                $display("FAIL fifo_order[%0d]: got %h want %h", k + 1, sd, exp_bits(ew[k]));
            end
        end
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL ovf_no_underrun: got %b want 0", underrun);
        end
        wait_strobe("ovf_drain");
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drained_underrun: got %b want 1", underrun);
        end
        capture_frame(sd, lr);
        total++;
        if (sd !== 64'h0) begin
            bad++;
            $display("FAIL drained_frame_zero: got %h want 0", sd);
        end
    endtask

    task automatic test_underrun();
        logic [63:0] sd, lr;
        clear_status();
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL und_clear: got %b want 0", underrun);
        end
        wait_strobe("und");
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL und_set: got %b want 1", underrun);
        end
        capture_frame(sd, lr);
        total++;
        if (sd !== 64'h0) begin
            bad++;
            $display("FAIL und_frame_zero: got %h want 0", sd);
        end
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL und_clr_again: got %b want 0", underrun);
        end
        repeat (5) @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        total++;
        if ({frame_strobe, underrun} !== 2'b10) begin
            bad++;
            $display("FAIL clr_wins: got strobe,und=%b want 10", {frame_strobe, underrun});
        end
        @(negedge clk);
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL clr_wins_hold: got %b want 0", underrun);
        end
        wait_strobe("und_reset");
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL und_set_again: got %b want 1", underrun);
        end
    endtask

    task automatic test_mute();
        logic [63:0] sd, lr;
        clear_status();
        send(32'h3F000000);
        mute = 1'b1;
        wait_strobe("mute");
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL mute_underrun: got %b want 0", underrun);
        end
        capture_frame(sd, lr);
        mute = 1'b0;
        total++;
        if (sd !== 64'h0) begin
            bad++;
            $display("FAIL mute_frame_zero: got %h want 0", sd);
        end
        wait_strobe("mute_pop");
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL mute_popped: got underrun %b want 1", underrun);
        end
    endtask

    task automatic test_aclr_mid();
        logic [63:0] sd, lr;
        logic        seen;
        bit          found;
        send(32'h3F7FFFFF);
        for (int i = 0; i < 4; i++) send(32'h3E800000);
        wait_strobe("aclr_pre");
        repeat (324) @(negedge clk);
        total++;
        if ({bclk, lrclk, sdata, overflow, underrun} !== 5'b11111) begin
            bad++;
            $display("FAIL aclr_pre_state: got %b want 11111", {bclk, lrclk, sdata, overflow, underrun});
        end
        #2 aclr = 1'b1;
        #1;
        total++;
        if ({bclk, lrclk, sdata, frame_strobe, fifo_full, clip, overflow, underrun} !== 8'h00) begin
            bad++;
            $display("FAIL aclr_async: got %b want 00000000",
                     {bclk, lrclk, sdata, frame_strobe, fifo_full, clip, overflow, underrun});
        end
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b0;
        send(32'hBF800000);
        seen  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (frame_strobe) begin
                found = 1'b1;
                break;
            end
            seen = seen | sdata;
        end
        total++;
        if (!found || cyc !== 512 || seen !== 1'b0) begin
            bad++;
            $display("FAIL aclr_silent_frame: got cyc=%0d found=%0b seen=%b want 512 1 0", cyc, found, seen);
        end
        total++;
        if ({overflow, underrun} !== 2'b00) begin
            bad++;
            $display("FAIL aclr_flags_after: got %b want 00", {overflow, underrun});
        end
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_bits(24'h800000)) begin
            bad++;
            $display("FAIL aclr_next_frame: got %h want %h", sd, exp_bits(24'h800000));
        end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_overflow();
        test_underrun();
        test_mute();
        test_aclr_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
